// File: rtl/instr_sequencer_pkg.sv
// ============================================================================
// Module : instr_sequencer_pkg
// Brief  : shared opcode, condition, state and field definitions
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FWAIT  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    CC_AL = 2'b00,
    CC_EQ = 2'b01,
    CC_NE = 2'b10,
    CC_MI = 2'b11
  } cond_t;

  localparam logic [3:0] c_OP_NOP  = 4'b0000;
  localparam logic [3:0] c_OP_LD   = 4'b1100;
  localparam logic [3:0] c_OP_ST   = 4'b1101;
  localparam logic [3:0] c_OP_HALT = 4'b1110;
  localparam logic [3:0] c_OP_BR   = 4'b1111;

  localparam int c_COND_HI = 15;
  localparam int c_COND_LO = 14;
  localparam int c_OPCD_HI = 13;
  localparam int c_OPCD_LO = 10;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_cond_check.sv
// ============================================================================
// Module : instr_sequencer_cond_check
// Brief  : evaluates the 2-bit condition field against the ALU flags
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer_cond_check
  import instr_sequencer_pkg::*;
(
  input  cond_t cond,
  input  logic  flag_z,
  input  logic  flag_n,
  output logic  pass
);

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_AL:   pass = 1'b1;
      CC_EQ:   pass = flag_z;
      CC_NE:   pass = ~flag_z;
      CC_MI:   pass = flag_n;
      default: pass = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module : instr_sequencer
// Brief  : multi-cycle fetch/decode/execute controller for the 16-bit core
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [PC_W-1:0]  rom_addr,
  output logic             rom_rd,
  input  logic [15:0]      rom_data,
  output logic [15:0]      inst,
  input  logic             flag_z,
  input  logic             flag_n,
  output logic             alu_en,
  output logic             flags_we,
  output logic             rf_we,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [PC_W-1:0]  c_PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [15:0]      r_inst;
  logic [15:0]      w_inst_nxt;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] w_retired_nxt;
  logic [3:0]       w_op;
  logic             w_cond_pass;

  assign w_op     = r_inst[c_OPCD_HI:c_OPCD_LO];
  assign rom_addr = r_pc;
  assign inst     = r_inst;
  assign retired  = r_retired;

  instr_sequencer_cond_check u_cond_check (
    .cond   (cond_t'(r_inst[c_COND_HI:c_COND_LO])),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .pass   (w_cond_pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_inst    <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_inst    <= w_inst_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  // Strobes depend on state only, so an async reset clears them at once.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_inst_nxt    = r_inst;
    w_retired_nxt = r_retired;
    rom_rd        = 1'b0;
    alu_en        = 1'b0;
    flags_we      = 1'b0;
    rf_we         = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    busy          = 1'b1;
    halted        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        rom_rd      = 1'b1;
        w_state_nxt = S_FWAIT;
      end
      S_FWAIT: begin
        w_inst_nxt  = rom_data;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!w_cond_pass) begin
          w_pc_nxt    = r_pc + c_PC_ONE;
          w_state_nxt = S_FETCH;
        end else begin
          case (w_op)
            c_OP_NOP: begin
              w_pc_nxt      = r_pc + c_PC_ONE;
              w_retired_nxt = r_retired + c_CNT_ONE;
              w_state_nxt   = S_FETCH;
            end
            c_OP_BR: begin
              w_pc_nxt      = r_inst[PC_W-1:0];
              w_retired_nxt = r_retired + c_CNT_ONE;
              w_state_nxt   = S_FETCH;
            end
            c_OP_HALT: begin
              w_retired_nxt = r_retired + c_CNT_ONE;
              w_state_nxt   = S_HALT;
            end
            c_OP_LD, c_OP_ST: w_state_nxt = S_MEM;
            default:          w_state_nxt = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        alu_en      = 1'b1;
        flags_we    = 1'b1;
        w_state_nxt = S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (w_op == c_OP_ST);
        if (mem_ack) begin
          if (w_op == c_OP_ST) begin
            w_pc_nxt      = r_pc + c_PC_ONE;
            w_retired_nxt = r_retired + c_CNT_ONE;
            w_state_nxt   = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we         = 1'b1;
        w_pc_nxt      = r_pc + c_PC_ONE;
        w_retired_nxt = r_retired + c_CNT_ONE;
        w_state_nxt   = S_FETCH;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
